// File: rtl/led_frame_builder.sv
// rtl/led_frame_builder.sv - double-buffered LED frame builder with row-scan output
module led_frame_builder #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [X_W-1:0]  in_x,
  input  logic [Y_W-1:0]  in_y,
  input  logic            in_mode,
  input  logic            frame_end,
  output logic            swap_pulse,
  output logic [ROWS-1:0] scan_row,
  output logic [COLS-1:0] scan_col,
  output logic [7:0]      oob_cnt
);

  localparam int XI_W  = $clog2(COLS);
  localparam int RI_W  = $clog2(ROWS);
  localparam int DIV_W = $clog2(SCAN_DIV);

  // Matrix limits widened by one bit so the full coordinate is compared (no aliasing).
  localparam logic [X_W:0] COLS_X = (X_W + 1)'(COLS);
  localparam logic [Y_W:0] ROWS_Y = (Y_W + 1)'(ROWS);

  typedef enum logic {
    S_DRAW  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          state_q;
  logic [RI_W-1:0] cnt_q;
  logic            front_sel_q;   // 0: buf0 is displayed, buf1 is drawn into
  logic            in_ready_q;
  logic            swap_q;
  logic [7:0]      oob_q;

  logic [COLS-1:0] buf0_q [ROWS];
  logic [COLS-1:0] buf1_q [ROWS];

  logic [DIV_W-1:0] div_q;
  logic [RI_W-1:0]  row_idx_q;
  logic [RI_W-1:0]  row_idx_d;
  logic [ROWS-1:0]  scan_row_q;
  logic [COLS-1:0]  scan_col_q;

  logic            draw;
  logic            accept;
  logic            in_range;
  logic            pix_we;
  logic [XI_W-1:0] wx;
  logic [RI_W-1:0] wy;
  logic            cur_bit;
  logic            pix_d;

  assign draw     = (state_q == S_DRAW);
  assign accept   = in_valid & draw;
  assign in_range = ({1'b0, in_x} < COLS_X) && ({1'b0, in_y} < ROWS_Y);
  assign wx       = in_x[XI_W-1:0];
  assign wy       = in_y[RI_W-1:0];

  // A pixel landing together with a bare clr would be wiped anyway, so it is dropped;
  // with frame_end it must land so it is part of the published frame.
  assign pix_we   = accept & in_range & (frame_end | ~clr);
  assign cur_bit  = front_sel_q ? buf0_q[wy][wx] : buf1_q[wy][wx];
  assign pix_d    = in_mode ? ~cur_bit : 1'b1;

  assign row_idx_d = (row_idx_q == RI_W'(ROWS - 1)) ? '0 : row_idx_q + RI_W'(1);

  // Back-buffer writes: pixel updates while drawing, one row zeroed per cycle while clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        buf0_q[r] <= '0;
        buf1_q[r] <= '0;
      end
    end else if (draw) begin
      if (pix_we) begin
        if (front_sel_q) buf0_q[wy][wx] <= pix_d;
        else             buf1_q[wy][wx] <= pix_d;
      end
    end else begin
      if (front_sel_q) buf0_q[cnt_q] <= '0;
      else             buf1_q[cnt_q] <= '0;
    end
  end

  // Control FSM: DRAW accepts pixels, frame_end swaps, both frame_end and clr enter CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DRAW;
      cnt_q       <= '0;
      front_sel_q <= 1'b0;
      in_ready_q  <= 1'b1;
      swap_q      <= 1'b0;
      oob_q       <= '0;
    end else begin
      swap_q <= 1'b0;
      if (accept && !in_range && oob_q != 8'hFF) begin
        oob_q <= oob_q + 8'd1;
      end
      case (state_q)
        S_DRAW: begin
          if (frame_end) begin
            front_sel_q <= ~front_sel_q;
            swap_q      <= 1'b1;
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
          end else if (clr) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt_q == RI_W'(ROWS - 1)) begin
            state_q    <= S_DRAW;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + RI_W'(1);
          end
        end
        default: begin
          state_q    <= S_DRAW;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Row scanner: advance one row every SCAN_DIV cycles and latch that row of the front buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      row_idx_q  <= '0;
      scan_row_q <= ROWS'(1);
      scan_col_q <= '0;
    end else begin
      scan_col_q <= front_sel_q ? buf1_q[row_idx_q] : buf0_q[row_idx_q];
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q      <= '0;
        row_idx_q  <= row_idx_d;
        scan_row_q <= ROWS'(1) << row_idx_d;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign swap_pulse = swap_q;
  assign scan_row   = scan_row_q;
  assign scan_col   = scan_col_q;
  assign oob_cnt    = oob_q;

endmodule
